// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and master-side signals around the I2C arbiter.
// The slave modport is the arbiter's view; master is the driving environment.
interface i2c_arbiter_if;
    logic [1:0]  Request_i;
    logic [1:0]  Grant_o;
    logic [1:0]  ReceiveSend_n_i;
    logic [15:0] ReadCount_i;
    logic [1:0]  StartProcess_i;
    logic [1:0]  FIFOReadNext_i;
    logic [1:0]  FIFOWrite_i;
    logic [15:0] Data_i;
    logic [1:0]  Busy_o;
    logic [1:0]  Error_o;
    logic        I2C_ReceiveSend_n_o;
    logic        I2C_StartProcess_o;
    logic        I2C_FIFOReadNext_o;
    logic        I2C_FIFOWrite_o;
    logic [7:0]  I2C_ReadCount_o;
    logic [7:0]  I2C_Data_o;
    logic        I2C_Busy_i;
    logic        I2C_Error_i;
    logic        Timeout_o;

    modport slave (
        input  Request_i, ReceiveSend_n_i, ReadCount_i, StartProcess_i,
               FIFOReadNext_i, FIFOWrite_i, Data_i, I2C_Busy_i, I2C_Error_i,
        output Grant_o, Busy_o, Error_o, I2C_ReceiveSend_n_o, I2C_StartProcess_o,
               I2C_FIFOReadNext_o, I2C_FIFOWrite_o, I2C_ReadCount_o, I2C_Data_o,
               Timeout_o
    );

    modport master (
        output Request_i, ReceiveSend_n_i, ReadCount_i, StartProcess_i,
               FIFOReadNext_i, FIFOWrite_i, Data_i, I2C_Busy_i, I2C_Error_i,
        input  Grant_o, Busy_o, Error_o, I2C_ReceiveSend_n_o, I2C_StartProcess_o,
               I2C_FIFOReadNext_o, I2C_FIFOWrite_o, I2C_ReadCount_o, I2C_Data_o,
               Timeout_o
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters.
// Optional idle-ownership watchdog enabled by defining I2CARB_TIMEOUT_EN.
module i2c_arbiter #(
    parameter logic [15:0] TimeoutCycles = 16'd1000
) (
    input logic          Clk_i,
    input logic          Reset_n_i,
    i2c_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        w_owner_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic        w_expire;
    logic [1:0]  w_req_elig;

    logic [1:0]  w_grant;
    logic [1:0]  w_busy;
    logic [1:0]  w_error;
    logic        w_rsn;
    logic        w_start;
    logic        w_frn;
    logic        w_fw;
    logic [7:0]  w_rc;
    logic [7:0]  w_data;

`ifdef I2CARB_TIMEOUT_EN
    logic [15:0] r_wd_cnt;
    logic [1:0]  r_blocked;
    logic        r_timeout;

    assign w_expire   = (r_state == S_OWN) && (r_wd_cnt == TimeoutCycles);
    assign w_req_elig = bus.Request_i & ~r_blocked;

    // A revoked requester stays blocked until its request has been seen low once.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_wd_cnt  <= '0;
            r_blocked <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if ((r_state != S_OWN) || bus.I2C_Busy_i || bus.StartProcess_i[r_owner])
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + 16'd1;
            r_blocked[0] <= (w_expire && !r_owner) ? 1'b1
                          : (bus.Request_i[0] ? r_blocked[0] : 1'b0);
            r_blocked[1] <= (w_expire && r_owner) ? 1'b1
                          : (bus.Request_i[1] ? r_blocked[1] : 1'b0);
        end
    end

    assign bus.Timeout_o = r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TimeoutCycles;
    assign w_expire         = 1'b0;
    assign w_req_elig       = bus.Request_i;
    assign bus.Timeout_o    = 1'b0;
`endif

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_grant     = 2'b00;
        w_busy      = 2'b11;
        w_error     = 2'b00;
        w_rsn       = 1'b0;
        w_start     = 1'b0;
        w_frn       = 1'b0;
        w_fw        = 1'b0;
        w_rc        = 8'h00;
        w_data      = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (|w_req_elig) begin
                    w_state_nxt = S_OWN;
                    // On a tie the requester that did not own last wins.
                    w_owner_nxt = (w_req_elig == 2'b11) ? ~r_last : w_req_elig[1];
                    w_last_nxt  = w_owner_nxt;
                end
            end
            S_OWN: begin
                if (!bus.Request_i[r_owner] || w_expire)
                    w_state_nxt = bus.I2C_Busy_i ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.I2C_Busy_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_state != S_IDLE) begin
            w_grant[r_owner] = 1'b1;
            w_busy[r_owner]  = bus.I2C_Busy_i;
            w_error[r_owner] = bus.I2C_Error_i;
            w_rsn            = bus.ReceiveSend_n_i[r_owner];
            w_start          = (r_state == S_OWN) && bus.StartProcess_i[r_owner];
            w_frn            = bus.FIFOReadNext_i[r_owner];
            w_fw             = bus.FIFOWrite_i[r_owner];
            w_rc             = r_owner ? bus.ReadCount_i[15:8] : bus.ReadCount_i[7:0];
            w_data           = r_owner ? bus.Data_i[15:8] : bus.Data_i[7:0];
        end
    end

    assign bus.Grant_o             = w_grant;
    assign bus.Busy_o              = w_busy;
    assign bus.Error_o             = w_error;
    assign bus.I2C_ReceiveSend_n_o = w_rsn;
    assign bus.I2C_StartProcess_o  = w_start;
    assign bus.I2C_FIFOReadNext_o  = w_frn;
    assign bus.I2C_FIFOWrite_o     = w_fw;
    assign bus.I2C_ReadCount_o     = w_rc;
    assign bus.I2C_Data_o          = w_data;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level ownership model.
module tb_i2c_arbiter;
    localparam logic [15:0] TC = 16'd10;

    logic Clk_i = 1'b0;
    logic Reset_n_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    i2c_arbiter_if bus();

    i2c_arbiter #(.TimeoutCycles(TC)) dut (
        .Clk_i     (Clk_i),
        .Reset_n_i (Reset_n_i),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: who owns the master (-1 = nobody), whether it is draining,
    // round-robin memory, watchdog idle count and blocked requesters.
    int       m_owner;
    bit       m_drain;
    int       m_last;
    bit [1:0] m_blk;
    int       m_cnt;
    bit       m_to;

    function automatic void model_reset();
        m_owner = -1; m_drain = 0; m_last = 1; m_blk = 0; m_cnt = 0; m_to = 0;
    endfunction

    function automatic void model_step();
        bit [1:0] req  = bus.Request_i;
        bit [1:0] elig;
        bit [1:0] setb = 0;
        bit       to_n = 0;
        bit       expire;
        if (m_owner < 0) begin
            elig = req & ~m_blk;
            if (elig != 0) begin
                m_owner = (elig == 2'b11) ? 1 - m_last : (elig[0] ? 0 : 1);
                m_last  = m_owner;
                m_cnt   = 0;
                m_drain = 0;
            end
        end else if (m_drain) begin
            if (!bus.I2C_Busy_i) begin m_owner = -1; m_drain = 0; end
        end else begin
`ifdef I2CARB_TIMEOUT_EN
            expire = (m_cnt == int'(TC));
`else
            expire = 0;
`endif
            if (expire) begin to_n = 1; setb[m_owner] = 1; end
            if (!req[m_owner] || expire) begin
                if (bus.I2C_Busy_i) m_drain = 1;
                else m_owner = -1;
            end else if (bus.I2C_Busy_i || bus.StartProcess_i[m_owner]) m_cnt = 0;
            else m_cnt++;
        end
        for (int n = 0; n < 2; n++) begin
            if (setb[n]) m_blk[n] = 1;
            else if (!req[n]) m_blk[n] = 0;
        end
        m_to = to_n;
    endfunction

    function automatic logic [1:0] e_grant();
        return (m_owner < 0) ? 2'b00 : (2'b01 << m_owner);
    endfunction

    function automatic logic [1:0] e_busy();
        logic [1:0] b = 2'b11;
        if (m_owner >= 0) b[m_owner] = bus.I2C_Busy_i;
        return b;
    endfunction

    function automatic logic [1:0] e_error();
        logic [1:0] e = 2'b00;
        if (m_owner >= 0) e[m_owner] = bus.I2C_Error_i;
        return e;
    endfunction

    function automatic logic [19:0] e_master();
        if (m_owner < 0) return 20'h0;
        return {bus.ReceiveSend_n_i[m_owner], m_drain ? 1'b0 : bus.StartProcess_i[m_owner],
                bus.FIFOReadNext_i[m_owner], bus.FIFOWrite_i[m_owner],
                bus.ReadCount_i[m_owner*8 +: 8], bus.Data_i[m_owner*8 +: 8]};
    endfunction

    function automatic logic [19:0] a_master();
        return {bus.I2C_ReceiveSend_n_o, bus.I2C_StartProcess_o, bus.I2C_FIFOReadNext_o,
                bus.I2C_FIFOWrite_o, bus.I2C_ReadCount_o, bus.I2C_Data_o};
    endfunction

    task automatic clear_inputs();
        bus.Request_i = 0; bus.ReceiveSend_n_i = 0; bus.ReadCount_i = 0;
        bus.StartProcess_i = 0; bus.FIFOReadNext_i = 0; bus.FIFOWrite_i = 0;
        bus.Data_i = 0; bus.I2C_Busy_i = 0; bus.I2C_Error_i = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset_n_i = 1'b0;
        model_reset();
        @(posedge Clk_i);
        #1;
        Reset_n_i = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n_i = 1'b0;
        model_reset();
        bus.Request_i = 2'b11; bus.StartProcess_i = 2'b11; bus.I2C_Busy_i = 1'b1;
        bus.ReadCount_i = 16'hFFFF; bus.Data_i = 16'hFFFF; bus.I2C_Error_i = 1'b1;
        @(posedge Clk_i); #1;
        total++; if (bus.Grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", bus.Grant_o); end
        total++; if (bus.Busy_o !== 2'b11) begin bad++; $display("FAIL reset_busy got=%b exp=11", bus.Busy_o); end
        total++; if (bus.Error_o !== 2'b00) begin bad++; $display("FAIL reset_error got=%b exp=00", bus.Error_o); end
        total++; if (a_master() !== 20'h0) begin bad++; $display("FAIL reset_master got=%h exp=0", a_master()); end
        total++; if (bus.Timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", bus.Timeout_o); end
        clear_inputs();
        Reset_n_i = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.Request_i = 2'b01; bus.ReadCount_i = 16'hA502;
        #1;
        total++; if (bus.Grant_o !== 2'b00) begin bad++; $display("FAIL single_pre got=%b exp=00", bus.Grant_o); end
        tick();
        total++; if (bus.Grant_o !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", bus.Grant_o); end
        total++; if (bus.I2C_ReadCount_o !== 8'h02) begin bad++; $display("FAIL single_rc got=%h exp=02", bus.I2C_ReadCount_o); end
        total++; if (bus.Busy_o !== 2'b10) begin bad++; $display("FAIL single_busy got=%b exp=10", bus.Busy_o); end
        bus.Request_i = 2'b00;
        tick();
        total++; if (bus.Grant_o !== 2'b00) begin bad++; $display("FAIL single_release got=%b exp=00", bus.Grant_o); end
    endtask

    task automatic test_alternation();
        int o = 0;
        logic [1:0] exp_g;
        do_reset();
        bus.Request_i = 2'b11;
        tick();
        total++; if (bus.Grant_o !== 2'b01) begin bad++; $display("FAIL alt_first got=%b exp=01", bus.Grant_o); end
        for (int r = 0; r < 6; r++) begin
            bus.Request_i = (o == 0) ? 2'b10 : 2'b01;
            tick();
            total++; if (bus.Grant_o !== 2'b00) begin bad++; $display("FAIL alt_gap%0d got=%b exp=00", r, bus.Grant_o); end
            bus.Request_i = 2'b11;
            tick();
            exp_g = (o == 0) ? 2'b10 : 2'b01;
            total++; if (bus.Grant_o !== exp_g) begin bad++; $display("FAIL alt_round%0d got=%b exp=%b", r, bus.Grant_o, exp_g); end
            o = 1 - o;
        end
        bus.Request_i = 2'b00;
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        bus.Request_i = 2'b10;
        tick();
        total++; if (bus.Grant_o !== 2'b10) begin bad++; $display("FAIL drain_own got=%b exp=10", bus.Grant_o); end
        bus.Request_i = 2'b00; bus.I2C_Busy_i = 1'b1;
        tick();
        bus.StartProcess_i = 2'b10;
        #1;
        total++; if (bus.Grant_o !== 2'b10) begin bad++; $display("FAIL drain_grant got=%b exp=10", bus.Grant_o); end
        total++; if (bus.I2C_StartProcess_o !== 1'b0) begin bad++; $display("FAIL drain_start got=%b exp=0", bus.I2C_StartProcess_o); end
        total++; if (bus.Busy_o !== 2'b11) begin bad++; $display("FAIL drain_busy got=%b exp=11", bus.Busy_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.Grant_o !== 2'b10) begin bad++; $display("FAIL drain_hold%0d got=%b exp=10", i, bus.Grant_o); end
        end
        bus.I2C_Busy_i = 1'b0; bus.StartProcess_i = 2'b00;
        tick();
        total++; if (bus.Grant_o !== 2'b00) begin bad++; $display("FAIL drain_exit got=%b exp=00", bus.Grant_o); end
    endtask

    task automatic test_error();
        do_reset();
        bus.Request_i = 2'b01;
        tick();
        bus.I2C_Error_i = 1'b1;
        #1;
        total++; if (bus.Error_o !== 2'b01) begin bad++; $display("FAIL error_owner got=%b exp=01", bus.Error_o); end
        bus.Request_i = 2'b00;
        tick();
        total++; if (bus.Error_o !== 2'b00) begin bad++; $display("FAIL error_idle got=%b exp=00", bus.Error_o); end
        bus.I2C_Error_i = 1'b0;
    endtask

`ifdef I2CARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.Request_i = 2'b01;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (bus.Grant_o !== 2'b01 || bus.Timeout_o !== 1'b0) begin
                bad++; $display("FAIL wd_hold%0d got=%b/%b exp=01/0", i, bus.Grant_o, bus.Timeout_o); end
        end
        tick();
        total++; if (bus.Grant_o !== 2'b00 || bus.Timeout_o !== 1'b1) begin
            bad++; $display("FAIL wd_fire got=%b/%b exp=00/1", bus.Grant_o, bus.Timeout_o); end
        bus.Request_i = 2'b11;
        tick();
        total++; if (bus.Grant_o !== 2'b10 || bus.Timeout_o !== 1'b0) begin
            bad++; $display("FAIL wd_other got=%b/%b exp=10/0", bus.Grant_o, bus.Timeout_o); end
        bus.Request_i = 2'b01;
        tick(); tick();
        total++; if (bus.Grant_o !== 2'b00) begin bad++; $display("FAIL wd_blocked got=%b exp=00", bus.Grant_o); end
        bus.Request_i = 2'b00;
        tick();
        bus.Request_i = 2'b01;
        tick();
        total++; if (bus.Grant_o !== 2'b01) begin bad++; $display("FAIL wd_unblock got=%b exp=01", bus.Grant_o); end
        bus.Request_i = 2'b00;
        tick();
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        bus.Request_i = 2'b01;
        tick();
        bus.I2C_Busy_i = 1'b1; bus.StartProcess_i = 2'b01;
        #1;
        total++; if (bus.I2C_StartProcess_o !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", bus.I2C_StartProcess_o); end
        #2;
        Reset_n_i = 1'b0;
        model_reset();
        #1;
        total++; if (bus.Grant_o !== 2'b00) begin bad++; $display("FAIL arst_grant got=%b exp=00", bus.Grant_o); end
        total++; if (a_master() !== 20'h0) begin bad++; $display("FAIL arst_master got=%h exp=0", a_master()); end
        total++; if (bus.Busy_o !== 2'b11 || bus.Error_o !== 2'b00) begin
            bad++; $display("FAIL arst_status got=%b/%b exp=11/00", bus.Busy_o, bus.Error_o); end
        clear_inputs();
        @(posedge Clk_i); #1;
        Reset_n_i = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 2; n++)
                if ($urandom_range(19) == 0) bus.Request_i[n] = ~bus.Request_i[n];
            if (bus.I2C_Busy_i) bus.I2C_Busy_i = ($urandom_range(2) != 0);
            else bus.I2C_Busy_i = ($urandom_range(15) == 0);
            bus.I2C_Error_i     = ($urandom_range(7) == 0);
            bus.StartProcess_i  = {($urandom_range(15) == 0), ($urandom_range(15) == 0)};
            bus.ReceiveSend_n_i = 2'($urandom);
            bus.FIFOReadNext_i  = 2'($urandom);
            bus.FIFOWrite_i     = 2'($urandom);
            bus.ReadCount_i     = 16'($urandom);
            bus.Data_i          = 16'($urandom);
            #1;
            total++; if (bus.Grant_o !== e_grant()) begin bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, bus.Grant_o, e_grant()); end
            total++; if (bus.Busy_o !== e_busy()) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.Busy_o, e_busy()); end
            total++; if (bus.Error_o !== e_error()) begin bad++; $display("FAIL rnd_error c=%0d got=%b exp=%b", c, bus.Error_o, e_error()); end
            total++; if (a_master() !== e_master()) begin bad++; $display("FAIL rnd_master c=%0d got=%h exp=%h", c, a_master(), e_master()); end
            total++; if (bus.Timeout_o !== m_to) begin bad++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, bus.Timeout_o, m_to); end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_alternation();
        test_drain();
        test_error();
`ifdef I2CARB_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
